// File: rtl/prb_tsync_loader.sv
`default_nettype none
// ============================================================================
// Module   : prb_tsync_loader
// Purpose  : Run-time loader for the time-sync preamble table, with a
//            registered correlator-style read port.
//            Optional define PRB_LOAD_CHECKSUM_EN adds the chk_sum output.
// Revision : 1.0 - initial release
// ============================================================================
module prb_tsync_loader #(
    parameter int DEPTH_RAM = 14,
    parameter int SEG_LEN   = 2048,
    parameter int N_BW      = 6,
    parameter int DW        = 24
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 abort,
    input  logic [2:0]           index_bw,
    input  logic [DW-1:0]        s_data,
    input  logic                 s_valid,
    output logic                 s_ready,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic [N_BW-1:0]      table_valid,
    input  logic [DEPTH_RAM-1:0] rd_addr,
    output logic [DW-1:0]        rd_dat
`ifdef PRB_LOAD_CHECKSUM_EN
    ,
    output logic [31:0]          chk_sum
`endif
);

    localparam int                 c_CNT_W     = $clog2(SEG_LEN);
    localparam int                 c_MEM_WORDS = N_BW * SEG_LEN;
    localparam logic [3:0]         c_BW_LIMIT  = 4'(N_BW);
    localparam logic [DEPTH_RAM:0] c_MEM_END   = (DEPTH_RAM + 1)'(N_BW * SEG_LEN);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST  = c_CNT_W'(SEG_LEN - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    state_t               r_state;
    logic [2:0]           r_bw;
    logic [c_CNT_W-1:0]   r_count;
    logic                 r_err;
    logic [N_BW-1:0]      r_table_valid;
    logic [DW-1:0]        r_mem [0:c_MEM_WORDS-1];

    logic                 w_start_ok;
    logic                 w_xfer;
    logic [DEPTH_RAM-1:0] w_wr_addr;
    logic [DEPTH_RAM:0]   w_rd_sum;
    logic                 w_rd_ok;

    // Segments are stacked downwards: the highest index sits at address 0.
    function automatic logic [DEPTH_RAM-1:0] seg_base(input logic [2:0] bw);
        int v;
        v = (N_BW - 1 - int'(bw)) * SEG_LEN;
        return DEPTH_RAM'(v);
    endfunction

    assign w_start_ok = start && ({1'b0, index_bw} < c_BW_LIMIT);
    assign w_xfer     = (r_state == S_LOAD) && s_valid && !abort;
    assign w_wr_addr  = seg_base(r_bw) + DEPTH_RAM'(r_count);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_bw          <= '0;
            r_count       <= '0;
            r_err         <= 1'b0;
            r_table_valid <= '0;
        end else begin
            r_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_start_ok) begin
                        r_bw                    <= index_bw;
                        r_table_valid[index_bw] <= 1'b0;
                        r_count                 <= '0;
                        r_state                 <= S_LOAD;
                    end else if (start) begin
                        r_err <= 1'b1;
                    end
                end
                S_LOAD: begin
                    if (abort) begin
                        r_err   <= 1'b1;
                        r_state <= S_IDLE;
                    end else if (s_valid) begin
                        r_count <= r_count + 1'b1;
                        if (r_count == c_CNT_LAST) begin
                            r_state <= S_FIN;
                        end
                    end
                end
                S_FIN: begin
                    r_table_valid[r_bw] <= 1'b1;
                    r_state             <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign s_ready     = (r_state == S_LOAD);
    assign busy        = (r_state == S_LOAD);
    assign done        = (r_state == S_FIN);
    assign err         = r_err;
    assign table_valid = r_table_valid;

    always_ff @(posedge clk) begin
        if (w_xfer) begin
            r_mem[w_wr_addr] <= s_data;
        end
    end

    // rd_addr is deliberately not masked to SEG_LEN: it may run into the next segment.
    assign w_rd_sum = {1'b0, rd_addr} + {1'b0, seg_base(index_bw)};
    assign w_rd_ok  = ({1'b0, index_bw} < c_BW_LIMIT) && (w_rd_sum < c_MEM_END);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_dat <= '0;
        end else if (w_rd_ok) begin
            rd_dat <= r_mem[w_rd_sum[DEPTH_RAM-1:0]];
        end else begin
            rd_dat <= '0;
        end
    end

`ifdef PRB_LOAD_CHECKSUM_EN
    logic [31:0] r_chk_sum;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_chk_sum <= '0;
        end else if ((r_state == S_IDLE) && w_start_ok) begin
            r_chk_sum <= '0;
        end else if (w_xfer) begin
            r_chk_sum <= r_chk_sum + 32'(s_data);
        end
    end

    assign chk_sum = r_chk_sum;
`endif

endmodule
`default_nettype wire

// File: tb/tb_prb_tsync_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_prb_tsync_loader
// Purpose  : Randomized self-checking bench for prb_tsync_loader against a
//            table-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_prb_tsync_loader;

    localparam int DEPTH_RAM = 14;
    localparam int SEG_LEN   = 2048;
    localparam int N_BW      = 6;
    localparam int DW        = 24;
    localparam int MEM_WORDS = N_BW * SEG_LEN;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 start;
    logic                 abort;
    logic [2:0]           index_bw;
    logic [DW-1:0]        s_data;
    logic                 s_valid;
    logic                 s_ready;
    logic                 busy;
    logic                 done;
    logic                 err;
    logic [N_BW-1:0]      table_valid;
    logic [DEPTH_RAM-1:0] rd_addr;
    logic [DW-1:0]        rd_dat;
`ifdef PRB_LOAD_CHECKSUM_EN
    logic [31:0]          chk_sum;
`endif

    prb_tsync_loader #(
        .DEPTH_RAM (DEPTH_RAM),
        .SEG_LEN   (SEG_LEN),
        .N_BW      (N_BW),
        .DW        (DW)
    ) u_dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .abort       (abort),
        .index_bw    (index_bw),
        .s_data      (s_data),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .table_valid (table_valid),
        .rd_addr     (rd_addr),
        .rd_dat      (rd_dat)
`ifdef PRB_LOAD_CHECKSUM_EN
        ,
        .chk_sum     (chk_sum)
`endif
    );

    always #5 clk = ~clk;

    // Reference model: flat preamble table plus per-segment valid flags.
    logic [DW-1:0]   m_mem   [MEM_WORDS];
    bit              m_known [MEM_WORDS];
    logic [N_BW-1:0] m_tv;
    int              n_vec;
    int              n_err;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void ref_read(input int bw, input int addr, output bit known, output logic [DW-1:0] val);
        int a;
        known = 1'b1;
        val   = '0;
        if (bw >= N_BW) return;
        a = (N_BW - 1 - bw) * SEG_LEN + addr;
        if (a >= MEM_WORDS) return;
        known = m_known[a];
        val   = m_mem[a];
    endfunction

    function automatic logic [DW-1:0] gen(input int kind, input int n);
        case (kind)
            0:       return DW'(n);
            1:       return 24'hA00000 + DW'(n);
            2:       return DW'($urandom);
            default: return 24'h000001;
        endcase
    endfunction

    // One clock: the read issued now is checked one edge later.
    task automatic tick();
        bit            k;
        logic [DW-1:0] v;
        ref_read(int'(index_bw), int'(rd_addr), k, v);
        @(negedge clk);
        if (k) check_eq("rd_dat", 32'(rd_dat), 32'(v));
    endtask

    task automatic check_ctl(input string ph, input bit e_busy, input bit e_done, input bit e_err);
        check_eq({ph, ".s_ready"}, 32'(s_ready), 32'(e_busy));
        check_eq({ph, ".busy"}, 32'(busy), 32'(e_busy));
        check_eq({ph, ".done"}, 32'(done), 32'(e_done));
        check_eq({ph, ".err"}, 32'(err), 32'(e_err));
        check_eq({ph, ".table_valid"}, 32'(table_valid), 32'(m_tv));
    endtask

    task automatic rd(input int bw, input int addr, input logic [DW-1:0] exp);
        index_bw = 3'(bw);
        rd_addr  = DEPTH_RAM'(addr);
        tick();
        check_eq("rd_explicit", 32'(rd_dat), 32'(exp));
    endtask

    // vmode: 0 continuous valid, 1 toggling, 2 random; abort_at < 0 means no abort
    task automatic do_load(input int bw, input int kind, input int vmode, input int abort_at);
        int            n;
        int            cyc;
        int            base;
        bit            v;
        logic [DW-1:0] d;
        logic [31:0]   sum;
        base  = (N_BW - 1 - bw) * SEG_LEN;
        sum   = '0;
        start = 1'b1;
        index_bw = 3'(bw);
        s_valid  = 1'b0;
        rd_addr  = DEPTH_RAM'($urandom_range(0, 16383));
        tick();
        start    = 1'b0;
        m_tv[bw] = 1'b0;
        check_ctl("entry", 1'b1, 1'b0, 1'b0);
        n   = 0;
        cyc = 0;
        while (n < SEG_LEN) begin
            case (vmode)
                0:       v = 1'b1;
                1:       v = ((cyc % 2) == 0);
                default: v = 1'($urandom_range(0, 1));
            endcase
            if (n == abort_at) v = 1'b1;
            d        = gen(kind, n);
            s_valid  = v;
            s_data   = d;
            abort    = (n == abort_at);
            start    = abort;
            index_bw = 3'($urandom_range(0, 7));
            rd_addr  = DEPTH_RAM'($urandom_range(0, 16383));
            tick();
            if (abort) begin
                abort   = 1'b0;
                start   = 1'b0;
                s_valid = 1'b0;
                check_ctl("abort", 1'b0, 1'b0, 1'b1);
                tick();
                check_ctl("post_abort", 1'b0, 1'b0, 1'b0);
                return;
            end
            if (v) begin
                m_mem[base + n]   = d;
                m_known[base + n] = 1'b1;
                sum = sum + 32'(d);
                n++;
            end
            cyc++;
            if (n < SEG_LEN) check_ctl("load", 1'b1, 1'b0, 1'b0);
            if (cyc > 20000) begin
                check_eq("load_budget", 32'(n), 32'(SEG_LEN));
                break;
            end
        end
        check_ctl("fin", 1'b0, 1'b1, 1'b0);
`ifdef PRB_LOAD_CHECKSUM_EN
        check_eq("chk_sum", chk_sum, sum);
`endif
        s_valid  = 1'b0;
        start    = 1'b1;
        index_bw = 3'($urandom_range(0, N_BW - 1));
        tick();
        start    = 1'b0;
        m_tv[bw] = 1'b1;
        check_ctl("idle", 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        n_vec    = 0;
        n_err    = 0;
        m_tv     = '0;
        rst      = 1'b1;
        start    = 1'b0;
        abort    = 1'b0;
        index_bw = '0;
        s_data   = '0;
        s_valid  = 1'b0;
        rd_addr  = '0;
        repeat (2) @(negedge clk);
        check_ctl("reset", 1'b0, 1'b0, 1'b0);
        check_eq("reset.rd_dat", 32'(rd_dat), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // bw5, s_data = count, continuous valid
        do_load(5, 0, 0, -1);
        check_eq("tv_bw5", 32'(table_valid), 32'h20);
        rd(5, 7, 24'd7);
        rd(5, 2048, m_mem[2048]);

        // reset in the middle of a bw3 load, then a normal bw3 load
        start    = 1'b1;
        index_bw = 3'd3;
        tick();
        start   = 1'b0;
        m_tv[3] = 1'b0;
        for (int i = 0; i < 100; i++) begin
            s_valid = 1'b1;
            s_data  = gen(2, i);
            tick();
            m_mem[4096 + i]   = s_data;
            m_known[4096 + i] = 1'b1;
        end
        s_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        m_tv = '0;
        check_ctl("mid_reset", 1'b0, 1'b0, 1'b0);
        check_eq("mid_reset.rd_dat", 32'(rd_dat), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        check_ctl("after_reset", 1'b0, 1'b0, 1'b0);
        do_load(3, 2, 2, -1);

        // bw0, A00000+n, toggling valid
        do_load(0, 1, 1, -1);
        rd(0, 0, 24'hA00000);
        rd(0, 2047, 24'hA007FF);
        rd(0, 2048, 24'h000000);

        // bad bandwidth index
        start    = 1'b1;
        index_bw = 3'd6;
        tick();
        start = 1'b0;
        check_ctl("bad_idx", 1'b0, 1'b0, 1'b1);
        tick();
        check_ctl("bad_idx_after", 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) rd(7, int'($urandom_range(0, 16383)), 24'h0);
        rd(6, 0, 24'h0);

        // bw2 full load, then reload aborted at count 500
        do_load(2, 2, 2, -1);
        do_load(2, 1, 0, 500);
        rd(2, 499, 24'hA00000 + 24'd499);
        rd(2, 500, m_mem[6144 + 500]);
        check_eq("tv_bw2_aborted", 32'(table_valid[2]), 32'd0);

        // bw4, all ones
        do_load(4, 3, 2, -1);
`ifdef PRB_LOAD_CHECKSUM_EN
        check_eq("chk_sum_bw4", chk_sum, 32'd2048);
`endif
        check_eq("tv_final", 32'(table_valid), 32'h19);

        for (int i = 0; i < 300; i++) begin
            index_bw = 3'($urandom_range(0, 7));
            rd_addr  = DEPTH_RAM'($urandom_range(0, 16383));
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
